// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage: PC, imem request/ready handshake, one-entry skid buffer, IF/ID register.
// Optional build macro IF_MISALIGN_CHK_EN: misaligned redirect targets raise a sticky fault and halt fetch.
//
// state  | meaning
// BOOT   | first cycle after reset release, no request issued
// FETCH  | normal fetch, accepted words go to IF/ID or the skid buffer
// DRAIN  | a request is outstanding whose response must be thrown away
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_inst,
    output logic        if_misalign
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] addr_q;
    logic [31:0] addr_next;
    logic        buf_valid;
    logic [31:0] buf_pc;
    logic [31:0] buf_inst;
    logic        fault;
    logic [31:0] target;
    logic        fire;
    logic        waiting;
    logic        accept;

`ifdef IF_MISALIGN_CHK_EN
    logic misalign_evt;

    assign target       = redirect_pc;
    assign misalign_evt = redirect && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault <= 1'b0;
        end else if (misalign_evt) begin
            fault <= 1'b1;
        end
    end
`else
    logic tgt_lo_unused;

    assign target        = {redirect_pc[31:2], 2'b00};
    assign fault         = 1'b0;
    assign tgt_lo_unused = ^redirect_pc[1:0];
`endif

    assign if_misalign = fault;
    assign imem_req    = (state != ST_BOOT) && !buf_valid && !fault;
    assign imem_addr   = addr_q;
    assign fire        = imem_req && imem_ready;
    assign waiting     = imem_req && !imem_ready;
    assign accept      = (state == ST_FETCH) && fire && !redirect;

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = target;
        end else if (accept) begin
            pc_next = pc + 32'd4;
        end
    end

    // The request address only moves once the current request has completed or none is open.
    assign addr_next = waiting ? addr_q : pc_next;

    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT:  state_next = ST_FETCH;
            ST_FETCH: if (redirect && waiting) state_next = ST_DRAIN;
            ST_DRAIN: if (fire) state_next = ST_FETCH;
            default:  state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_BOOT;
            pc     <= RESET_PC;
            addr_q <= RESET_PC;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            addr_q <= addr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid  <= 1'b0;
            id_pc     <= 32'h0000_0000;
            id_pc4    <= 32'h0000_0004;
            id_inst   <= NOP_INST;
            buf_valid <= 1'b0;
            buf_pc    <= 32'h0000_0000;
            buf_inst  <= NOP_INST;
        end else if (redirect) begin
            id_valid  <= 1'b0;
            id_inst   <= NOP_INST;
            buf_valid <= 1'b0;
        end else if (stall) begin
            // Decode is frozen; a word landing now is parked in the skid buffer.
            if (accept) begin
                buf_valid <= 1'b1;
                buf_pc    <= addr_q;
                buf_inst  <= imem_rdata;
            end
        end else if (buf_valid) begin
            id_valid  <= 1'b1;
            id_pc     <= buf_pc;
            id_pc4    <= buf_pc + 32'd4;
            id_inst   <= buf_inst;
            buf_valid <= 1'b0;
        end else if (accept) begin
            id_valid <= 1'b1;
            id_pc    <= addr_q;
            id_pc4   <= addr_q + 32'd4;
            id_inst  <= imem_rdata;
        end else begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: in-order stream model checked every cycle plus directed cycle-exact expectations.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] XM  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_inst;
    logic        if_misalign;

    int total = 0;
    int bad = 0;
    int wait_cfg = 0;
    int wcnt = 0;

    if_fetch_stage dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_pc(id_pc), .id_pc4(id_pc4), .id_inst(id_inst),
        .if_misalign(if_misalign)
    );

    always #5 clk = ~clk;

    // Memory: each request waits wait_cfg cycles, data is a fixed function of the address.
    assign imem_ready = imem_req && (wcnt == 0);
    assign imem_rdata = imem_addr ^ XM;

    always @(posedge clk) begin
        if (rst) wcnt <= wait_cfg;
        else if (imem_req && imem_ready) wcnt <= wait_cfg;
        else if (imem_req && wcnt != 0) wcnt <= wcnt - 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stream model: decode must see consecutive PCs from the last redirect target, nothing lost or repeated.
    logic [31:0] exp_pc = 32'h0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic        fault_m = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            chk1("rst_req", imem_req, 1'b0);
            chk1("rst_valid", id_valid, 1'b0);
            chk("rst_id_pc", id_pc, 32'h0);
            chk("rst_id_pc4", id_pc4, 32'h4);
            chk("rst_id_inst", id_inst, NOP);
            chk1("rst_misalign", if_misalign, 1'b0);
            exp_pc    = 32'h0;
            prev_wait = 1'b0;
            fault_m   = 1'b0;
        end else begin
            if (prev_wait) begin
                chk1("hold_req", imem_req, 1'b1);
                chk("hold_addr", imem_addr, prev_addr);
            end
            chk1("misalign_flag", if_misalign, fault_m);
            if (fault_m) begin
                chk1("fault_req", imem_req, 1'b0);
                chk1("fault_valid", id_valid, 1'b0);
            end else if (redirect) begin
`ifdef IF_MISALIGN_CHK_EN
                if (redirect_pc[1:0] != 2'b00) fault_m = 1'b1;
`endif
                exp_pc = {redirect_pc[31:2], 2'b00};
            end else if (id_valid && !stall) begin
                chk("stream_pc", id_pc, exp_pc);
                chk("stream_inst", id_inst, exp_pc ^ XM);
                chk("stream_pc4", id_pc4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
            end
            prev_wait = imem_req && !imem_ready;
            prev_addr = imem_addr;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;                                         // c1: BOOT
        #1 chk1("boot_req", imem_req, 1'b0);
        step();                                                // c2: first request
        chk1("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 32'h0);
        chk1("first_valid", id_valid, 1'b0);
        step();                                                // c3
        chk1("c3_valid", id_valid, 1'b1);
        chk("c3_pc", id_pc, 32'h0);
        chk("c3_inst", id_inst, 32'hA5A5_0000);
        chk("c3_addr", imem_addr, 32'h4);
        step();
        chk("c4_pc", id_pc, 32'h4);
        step();
        chk("c5_pc", id_pc, 32'h8);
        chk("c5_pc4", id_pc4, 32'hC);
        wait_cfg = 2;
        step();                                                // c6
        chk("c6_pc", id_pc, 32'hC);
        chk("c6_addr", imem_addr, 32'h10);
        step();
        chk1("c7_valid", id_valid, 1'b0);
        chk("c7_addr", imem_addr, 32'h10);
        step();
        chk1("c8_ready", imem_ready, 1'b1);
        step();
        chk1("c9_valid", id_valid, 1'b1);
        chk("c9_pc", id_pc, 32'h10);
        step();
        chk1("c10_valid", id_valid, 1'b0);
        step();                                                // c11
        step();                                                // c12: stall begins
        stall = 1'b1;
        #1 chk("c12_pc", id_pc, 32'h14);
        step();
        wait_cfg = 0;
        chk1("c13_valid", id_valid, 1'b1);
        chk("c13_pc_hold", id_pc, 32'h14);
        step();                                                // c14: word 0x18 goes to skid buffer
        chk1("c14_ready", imem_ready, 1'b1);
        chk("c14_addr", imem_addr, 32'h18);
        chk("c14_pc_hold", id_pc, 32'h14);
        step();                                                // c15: release
        stall = 1'b0;
        #1 chk1("c15_req_buf", imem_req, 1'b0);
        chk("c15_pc", id_pc, 32'h14);
        step();
        chk("c16_pc", id_pc, 32'h18);
        chk1("c16_req", imem_req, 1'b1);
        chk("c16_addr", imem_addr, 32'h1C);
        wait_cfg = 2;
        step();                                                // c17: redirect while 0x20 waits
        redirect = 1'b1;
        redirect_pc = 32'h100;
        #1 chk("c17_pc", id_pc, 32'h1C);
        chk("c17_addr", imem_addr, 32'h20);
        chk1("c17_ready", imem_ready, 1'b0);
        step();                                                // c18: DRAIN
        redirect = 1'b0;
        wait_cfg = 0;
        #1 chk1("c18_valid", id_valid, 1'b0);
        chk("c18_inst", id_inst, NOP);
        chk1("c18_req", imem_req, 1'b1);
        chk("c18_addr", imem_addr, 32'h20);
        step();
        chk1("c19_ready", imem_ready, 1'b1);
        chk("c19_addr", imem_addr, 32'h20);
        step();
        chk("c20_addr", imem_addr, 32'h100);
        chk1("c20_valid", id_valid, 1'b0);
        step();
        chk("c21_pc", id_pc, 32'h100);
        chk("c21_inst", id_inst, 32'hA5A5_0100);
        step();                                                // c22: stall fills buffer
        stall = 1'b1;
        #1 chk("c22_pc", id_pc, 32'h104);
        step();                                                // c23: redirect with full buffer
        redirect = 1'b1;
        redirect_pc = 32'h200;
        #1 chk1("c23_req", imem_req, 1'b0);
        chk("c23_pc", id_pc, 32'h104);
        step();
        redirect = 1'b0;
        stall = 1'b0;
        #1 chk1("c24_valid", id_valid, 1'b0);
        chk("c24_inst", id_inst, NOP);
        chk1("c24_req", imem_req, 1'b1);
        chk("c24_addr", imem_addr, 32'h200);
        step();
        chk("c25_pc", id_pc, 32'h200);
        chk("c25_inst", id_inst, 32'hA5A5_0200);
        step();                                                // c26: redirect coincident with ready
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        #1 chk1("c26_ready", imem_ready, 1'b1);
        step();
        redirect = 1'b0;
        #1 chk1("c27_valid", id_valid, 1'b0);
        chk("c27_addr", imem_addr, 32'hFFFF_FFF8);
        step();
        chk("c28_pc", id_pc, 32'hFFFF_FFF8);
        step();
        chk("c29_pc", id_pc, 32'hFFFF_FFFC);
        chk("c29_pc4_wrap", id_pc4, 32'h0);
        chk("c29_addr_wrap", imem_addr, 32'h0);
        step();                                                // c30: misaligned redirect
        redirect = 1'b1;
        redirect_pc = 32'h102;
        #1 chk("c30_pc", id_pc, 32'h0);
        chk("c30_pc4", id_pc4, 32'h4);
        step();
        redirect = 1'b0;
        #1;
`ifdef IF_MISALIGN_CHK_EN
        chk1("c31_misalign", if_misalign, 1'b1);
        chk1("c31_req", imem_req, 1'b0);
        step();
        chk1("c32_req", imem_req, 1'b0);
        chk1("c32_valid", id_valid, 1'b0);
        step();
        chk1("c33_req_pre", imem_req, 1'b0);
`else
        chk1("c31_misalign", if_misalign, 1'b0);
        chk1("c31_req", imem_req, 1'b1);
        chk("c31_addr", imem_addr, 32'h100);
        step();
        chk1("c32_valid", id_valid, 1'b1);
        chk("c32_pc", id_pc, 32'h100);
        step();
        chk1("c33_req_pre", imem_req, 1'b1);
`endif
        rst = 1'b1;                                            // c33: reset mid-request
        #1 chk1("c33_req_rst", imem_req, 1'b0);
        chk1("c33_valid_rst", id_valid, 1'b0);
        chk1("c33_misalign_rst", if_misalign, 1'b0);
        chk("c33_inst_rst", id_inst, NOP);
        step();
        step();
        rst = 1'b0;                                            // c35: BOOT again
        #1 chk1("c35_req", imem_req, 1'b0);
        step();
        chk1("c36_req", imem_req, 1'b1);
        chk("c36_addr", imem_addr, 32'h0);
        step();
        chk1("c37_valid", id_valid, 1'b1);
        chk("c37_pc", id_pc, 32'h0);
        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the 5-stage RV32I pipeline. It owns the program counter and issues requests to instruction memory with a ready handshake. It absorbs decode stalls with a one-entry skid buffer and drives the IF/ID pipeline register. Decode consumes `id_pc`/`id_inst` to form branch targets; the resolved target returns here on `redirect`/`redirect_pc`.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INST`, default 32'h0000_0013: encoding placed in `id_inst` when flushed or at reset (`addi x0,x0,0`).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address, stable while `imem_req` is high and `imem_ready` is low.
- `imem_ready`  in  1  response valid this cycle; may be combinational on `imem_req`.
- `imem_rdata`  in  32  instruction word, sampled when `imem_req && imem_ready`.
- `stall`  in  1  decode cannot accept; IF/ID holds.
- `redirect`  in  1  taken branch/jump; flush and refetch.
- `redirect_pc`  in  32  target address from branch-address logic.
- `id_valid`  out  1  IF/ID holds a real instruction.
- `id_pc`  out  32  PC of `id_inst`.
- `id_pc4`  out  32  `id_pc + 4`.
- `id_inst`  out  32  fetched instruction.
- `if_misalign`  out  1  misaligned redirect fault; see Configuration.

## Operation
- Registers:
  - `pc`: next fetch address.
  - `addr_q`: outstanding request address, drives `imem_addr`.
  - skid buffer `buf_valid`/`buf_pc`/`buf_inst`.
  - 2-bit state.
- States:
  - BOOT: one cycle after reset release, `imem_req=0`; goes to FETCH.
  - FETCH: normal operation.
  - DRAIN: a request is outstanding but its response must be discarded.
- `imem_req = (state!=BOOT) && !buf_valid && !fault`.
- In FETCH, `addr_q` loads `pc` when a new request launches. `addr_q` is held constant until `imem_ready`.
- Accept = FETCH && `imem_req && imem_ready` && !`redirect`. On accept: `pc <= pc+4`.
  - If `!stall`, the word goes to IF/ID.
  - If `stall`, the word goes to the skid buffer (`buf_valid<=1`).
- IF/ID update priority, highest first:
  1. `redirect`: `id_valid<=0`, `id_inst<=NOP_INST`, `buf_valid<=0`, `pc<=redirect_pc`.
  2. `stall`: hold all IF/ID fields.
  3. `buf_valid`: IF/ID <= buffer, `buf_valid<=0`.
  4. Accept: IF/ID <= {addr_q, imem_rdata}.
  5. Otherwise: `id_valid<=0` (bubble). `id_pc`/`id_inst` are don't-care but keep their last value.
- Redirect in FETCH with request outstanding and `imem_ready=0`: go to DRAIN. `addr_q` is kept; `pc` takes the target.
- Redirect in FETCH coinciding with `imem_ready=1`: the response is dropped and the stage stays in FETCH.
- DRAIN: `imem_req=1` at the old `addr_q`. On `imem_ready`, the response is discarded and the stage goes to FETCH.
- A further redirect in DRAIN updates `pc` only.
- `id_pc4` is registered alongside `id_pc`.
- All additions are modulo 2^32; `pc` wraps from 32'hFFFF_FFFC to 0 silently.

## Timing
- Reset values:
  - `pc=RESET_PC`, `addr_q=RESET_PC`, state BOOT.
  - `imem_req=0`, `id_valid=0`, `id_pc=0`, `id_pc4=4`, `id_inst=NOP_INST`.
  - `buf_valid=0`, `if_misalign=0`.
- First request: `imem_req=1` in the second cycle after `rst` falls.
- Zero-wait memory: one instruction per cycle. `id_*` is valid the cycle after acceptance.
- Stall: at most one word is in flight beyond IF/ID, and no request is issued while `buf_valid=1`. On stall release, the buffer drains in one cycle, and fetch restarts in that same cycle.
- Redirect penalty with zero-wait memory: the target is requested the cycle after `redirect`; the first target instruction reaches `id_*` two cycles after `redirect`.
- Asserting `rst` mid-request abandons the request immediately. Memory must tolerate `imem_req` dropping.

## Configuration
- `IF_MISALIGN_CHK_EN` defined:
  - A redirect with `redirect_pc[1:0]!=0` sets sticky `if_misalign=1`.
  - The same event forces `imem_req=0` and `id_valid=0` until reset.
- Not defined:
  - `if_misalign` is tied 0.
  - `redirect_pc[1:0]` is ignored; the target is loaded as `{redirect_pc[31:2],2'b00}`.

## Test plan
- Reset, zero-wait memory returning `addr^32'hA5A5_0000`, no stall/redirect: requests 0,4,8,…; `id_pc` 0,4,8 on consecutive cycles; `id_valid` rises 3 cycles after `rst` falls.
- `imem_ready` low 2 cycles per request: `imem_addr` is stable during wait; `id_valid` pulses once per 3 cycles with correct `id_pc`.
- `stall` held 3 cycles while a response arrives: IF/ID holds, `buf_valid=1`, `imem_req=0`; after release, the buffered word appears next cycle and fetch resumes with no lost or duplicated PC.
- `redirect` to 32'h100 while a request to 32'h20 waits: the stage enters DRAIN, the 0x20 word is discarded, the next request is 0x100, and `id_inst=NOP_INST` during the flush.
- `redirect` coincident with `stall` and a full buffer: the buffer is cleared, `id_valid=0`, and the next fetch is at the target.
- With `IF_MISALIGN_CHK_EN`: redirect to 32'h102 gives `if_misalign=1` and no further requests. Without it, the fetch goes to 32'h100.
